qed_dup_scheduler: RTL and testbench

- Sits between the fetch stage and the decoder in the SQED wrapper.
- Issues each original instruction (registers x0–x15) straight through, and queues its duplicate with register fields remapped to x16–x31.
- Drains the duplicate queue in order, so the commit-count equality checker sees matched original/duplicate sequences.
- Also flags issue-side consistency with a `qed_sync` output.

---
 rtl/qed_dup_scheduler_pkg.sv | 31 +++
 rtl/qed_dup_scheduler_if.sv | 28 ++
 rtl/qed_dup_scheduler_remap.sv | 63 ++++++
 rtl/qed_dup_scheduler.sv | 148 ++++++++++++++
 tb/tb_qed_dup_scheduler.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/qed_dup_scheduler_pkg.sv
// qed_pkg: shared definitions for the SQED duplicate scheduler.
//   - RV32 opcode constants that carry register fields
//   - register-field bit positions and the bank bit that splits x0-x15 / x16-x31
//   - default NOP encoding (addi x0,x0,0)
//   - scheduler state enum
package qed_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    localparam int unsigned RD_LSB   = 7;
    localparam int unsigned RS1_LSB  = 15;
    localparam int unsigned RS2_LSB  = 20;
    localparam int unsigned REG_W    = 5;
    localparam int unsigned BANK_BIT = 4;

    localparam logic [31:0] NOP_INST_DFLT = 32'h00000013;

    typedef enum logic {
        ORIG,
        DUP
    } state_t;

endpackage

// File: rtl/qed_dup_scheduler_if.sv
// qed_dup_scheduler_if: fetch-side and decode-side handshake bundle of the
// duplicate scheduler.
//   slave  : the scheduler (consumes in_*, exec_dup, out_ready; drives the rest)
//   master : the surrounding wrapper / fetch+decode side
interface qed_dup_scheduler_if #(
    parameter int unsigned INST_LEN = 32
);
    logic [INST_LEN-1:0] in_inst;
    logic                in_valid;
    logic                in_ready;
    logic                exec_dup;
    logic [INST_LEN-1:0] out_inst;
    logic                out_valid;
    logic                out_ready;
    logic                out_is_dup;
    logic                qed_sync;
    logic                illegal_orig;

    modport master (
        output in_inst, in_valid, exec_dup, out_ready,
        input  in_ready, out_inst, out_valid, out_is_dup, qed_sync, illegal_orig
    );

    modport slave (
        input  in_inst, in_valid, exec_dup, out_ready,
        output in_ready, out_inst, out_valid, out_is_dup, qed_sync, illegal_orig
    );
endinterface

// File: rtl/qed_dup_scheduler_remap.sv
// qed_reg_remap: combinational register-bank remapper.
//   inst     in  original instruction
//   remapped out same instruction with every used nonzero rd/rs1/rs2 moved to x16-x31
//   illegal  out a used register field already points into x16-x31
// Opcodes without register fields pass through untouched.
module qed_reg_remap
    import qed_pkg::*;
#(
    parameter int unsigned INST_LEN = 32
) (
    input  logic [INST_LEN-1:0] inst,
    output logic [INST_LEN-1:0] remapped,
    output logic                illegal
);

    logic [REG_W-1:0] rd;
    logic [REG_W-1:0] rs1;
    logic [REG_W-1:0] rs2;
    logic             use_rd;
    logic             use_rs1;
    logic             use_rs2;

    assign rd  = inst[RD_LSB  +: REG_W];
    assign rs1 = inst[RS1_LSB +: REG_W];
    assign rs2 = inst[RS2_LSB +: REG_W];

    always_comb begin
        use_rd  = 1'b0;
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        case (inst[6:0])
            OP_R: begin
                use_rd  = 1'b1;
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
            end
            OP_IMM, OP_LOAD, OP_JALR: begin
                use_rd  = 1'b1;
                use_rs1 = 1'b1;
            end
            OP_STORE, OP_BRANCH: begin
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
            end
            OP_LUI, OP_AUIPC, OP_JAL: begin
                use_rd  = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        remapped = inst;
        // x0 is hard-wired zero in both banks, so it is never moved
        if (use_rd  && rd  != '0) remapped[RD_LSB  + BANK_BIT] = 1'b1;
        if (use_rs1 && rs1 != '0) remapped[RS1_LSB + BANK_BIT] = 1'b1;
        if (use_rs2 && rs2 != '0) remapped[RS2_LSB + BANK_BIT] = 1'b1;
        illegal = (use_rd  && rd[BANK_BIT])  ||
                  (use_rs1 && rs1[BANK_BIT]) ||
                  (use_rs2 && rs2[BANK_BIT]);
    end

endmodule

// File: rtl/qed_dup_scheduler.sv
// qed_dup_scheduler: issues originals (x0-x15) straight to the decoder and
// queues their x16-x31 duplicates, draining the queue in order in DUP mode.
//   clk, rst_n  clock, asynchronous active-low reset
//   bus         qed_dup_scheduler_if.slave (in_*, exec_dup, out_*, qed_sync,
//               illegal_orig)
//   stat_orig, stat_dup, stat_stall  saturating statistics, only present when
//               QED_DUP_STATS_EN is defined
module qed_dup_scheduler
    import qed_pkg::*;
#(
    parameter int unsigned         DEPTH    = 8,
    parameter int unsigned         INST_LEN = 32,
    parameter logic [INST_LEN-1:0] NOP_INST = INST_LEN'(NOP_INST_DFLT)
) (
    input  logic                clk,
    input  logic                rst_n,
    qed_dup_scheduler_if.slave  bus
`ifdef QED_DUP_STATS_EN
    ,
    output logic [31:0]         stat_orig,
    output logic [31:0]         stat_dup,
    output logic [31:0]         stat_stall
`endif
);

    localparam int unsigned  PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);
    localparam logic [PTR_W:0] LAST_CNT = (PTR_W + 1)'(DEPTH - 1);

    state_t              state;
    state_t              state_nxt;
    logic [INST_LEN-1:0] mem [DEPTH];
    logic [PTR_W-1:0]    wr_ptr;
    logic [PTR_W-1:0]    rd_ptr;
    logic [PTR_W:0]      count;
    logic [15:0]         orig_cnt;
    logic [15:0]         dup_cnt;
    logic [INST_LEN-1:0] out_inst_q;
    logic                out_valid_q;
    logic                out_dup_q;
    logic                illegal_q;
    logic                in_ready_c;
    logic                slot_free;
    logic                q_empty;
    logic                q_full;
    logic                push;
    logic                pop;
    logic [INST_LEN-1:0] remapped;
    logic                illegal;

    qed_reg_remap #(.INST_LEN(INST_LEN)) u_remap (
        .inst     (bus.in_inst),
        .remapped (remapped),
        .illegal  (illegal)
    );

    assign slot_free = !out_valid_q || bus.out_ready;
    assign q_empty   = (count == '0);
    assign q_full    = (count == FULL_CNT);
    assign push      = bus.in_valid && in_ready_c;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ORIG;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ORIG: if (bus.exec_dup || (push && count == LAST_CNT)) state_nxt = DUP;
            // leave only once the last duplicate has left the output slot
            DUP:  if (q_empty && slot_free) state_nxt = ORIG;
            default: state_nxt = ORIG;
        endcase
    end

    always_comb begin
        in_ready_c = 1'b0;
        pop        = 1'b0;
        case (state)
            // rst_n gate keeps in_ready low while reset is asserted
            ORIG: in_ready_c = rst_n && slot_free && !q_full && !bus.exec_dup;
            DUP:  pop        = slot_free && !q_empty;
            default: ;
        endcase
    end

    // push and pop are mode-exclusive, so one branch covers the whole datapath
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            orig_cnt    <= '0;
            dup_cnt     <= '0;
            out_inst_q  <= NOP_INST;
            out_valid_q <= 1'b0;
            out_dup_q   <= 1'b0;
            illegal_q   <= 1'b0;
        end else begin
            illegal_q <= push && illegal;
            if (push) begin
                wr_ptr      <= wr_ptr + 1'b1;
                count       <= count + 1'b1;
                orig_cnt    <= orig_cnt + 1'b1;
                out_inst_q  <= illegal ? NOP_INST : bus.in_inst;
                out_valid_q <= 1'b1;
                out_dup_q   <= 1'b0;
            end else if (pop) begin
                rd_ptr      <= rd_ptr + 1'b1;
                count       <= count - 1'b1;
                dup_cnt     <= dup_cnt + 1'b1;
                out_inst_q  <= mem[rd_ptr];
                out_valid_q <= 1'b1;
                out_dup_q   <= 1'b1;
            end else if (bus.out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= illegal ? NOP_INST : remapped;
    end

    assign bus.in_ready     = in_ready_c;
    assign bus.out_inst     = out_inst_q;
    assign bus.out_valid    = out_valid_q;
    assign bus.out_is_dup   = out_dup_q;
    assign bus.illegal_orig = illegal_q;
    assign bus.qed_sync     = q_empty && (orig_cnt == dup_cnt);

`ifdef QED_DUP_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_orig  <= '0;
            stat_dup   <= '0;
            stat_stall <= '0;
        end else begin
            if (push && stat_orig != '1) stat_orig <= stat_orig + 1'b1;
            if (pop  && stat_dup  != '1) stat_dup  <= stat_dup + 1'b1;
            if (out_valid_q && !bus.out_ready && stat_stall != '1)
                stat_stall <= stat_stall + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_qed_dup_scheduler.sv
// tb_qed_dup_scheduler: directed self-checking bench for qed_dup_scheduler.
// Accepted outputs are logged at the falling edge and compared against
// hand-computed original/duplicate sequences.
module tb_qed_dup_scheduler;

    localparam logic [31:0] NOP = 32'h00000013;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    qed_dup_scheduler_if #(.INST_LEN(32)) bus ();

`ifdef QED_DUP_STATS_EN
    logic [31:0] stat_orig;
    logic [31:0] stat_dup;
    logic [31:0] stat_stall;
`endif

    qed_dup_scheduler #(
        .DEPTH    (8),
        .INST_LEN (32),
        .NOP_INST (NOP)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
`ifdef QED_DUP_STATS_EN
        ,
        .stat_orig  (stat_orig),
        .stat_dup   (stat_dup),
        .stat_stall (stat_stall)
`endif
    );

    int errors = 0;
    int checks = 0;

    logic [32:0] mon_q[$];
    logic [32:0] exp_q[$];

    always @(negedge clk) begin
        if (rst_n && bus.out_valid && bus.out_ready)
            mon_q.push_back({bus.out_is_dup, bus.out_inst});
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [31:0] inst);
        bus.in_inst  = inst;
        bus.in_valid = 1'b1;
        @(negedge clk);
        chk("issue_in_ready", bus.in_ready, 1);
        step();
        bus.in_valid = 1'b0;
    endtask

    task automatic pulse_exec();
        bus.exec_dup = 1'b1;
        step();
        bus.exec_dup = 1'b0;
    endtask

    task automatic drain(input string tag);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(bus.in_ready && !bus.out_valid) && n < 40);
        chk(tag, bus.in_ready, 1);
        step();
    endtask

    task automatic compare_mon(input string tag);
        chk({tag, "_len"}, mon_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < mon_q.size(); i++)
            chk($sformatf("%s_%0d", tag, i), mon_q[i], exp_q[i]);
        mon_q.delete();
        exp_q.delete();
    endtask

    function automatic logic [31:0] addi_inst(input int unsigned r, input int unsigned imm);
        logic [4:0]  rr;
        logic [11:0] im;
        rr = r[4:0];
        im = imm[11:0];
        return {im, rr, 3'b000, rr, 7'b0010011};
    endfunction

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] a;
        bus.in_inst   = '0;
        bus.in_valid  = 1'b0;
        bus.exec_dup  = 1'b0;
        bus.out_ready = 1'b1;

        // reset values
        #12;
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_inst", bus.out_inst, NOP);
        chk("rst_out_is_dup", bus.out_is_dup, 0);
        chk("rst_in_ready", bus.in_ready, 0);
        chk("rst_illegal", bus.illegal_orig, 0);
        chk("rst_qed_sync", bus.qed_sync, 1);
        #1 rst_n = 1'b1;
        step();
        mon_q.delete();

        // add x3,x1,x2 -> add x19,x17,x18
        issue(32'h002081B3);
        @(negedge clk);
        chk("t1_orig_inst", bus.out_inst, 32'h002081B3);
        chk("t1_orig_not_dup", bus.out_is_dup, 0);
        chk("t1_no_illegal", bus.illegal_orig, 0);
        chk("t1_sync_pending", bus.qed_sync, 0);
        step();
        pulse_exec();
        drain("t1_drain");
        exp_q.push_back({1'b0, 32'h002081B3});
        exp_q.push_back({1'b1, 32'h012889B3});
        compare_mon("t1_seq");
        chk("t1_sync", bus.qed_sync, 1);

        // lui x5 and sw x6,0(x7)
        issue(32'h000122B7);
        issue(32'h0063A023);
        pulse_exec();
        drain("t2_drain");
        exp_q.push_back({1'b0, 32'h000122B7});
        exp_q.push_back({1'b0, 32'h0063A023});
        exp_q.push_back({1'b1, 32'h00012AB7});
        exp_q.push_back({1'b1, 32'h016BA023});
        compare_mon("t2_seq");
        chk("t2_sync", bus.qed_sync, 1);

        // fill queue to DEPTH without exec_dup
        for (int k = 0; k < 8; k++) issue(addi_inst(k + 1, k));
        bus.in_inst  = addi_inst(9, 9);
        bus.in_valid = 1'b1;
        @(negedge clk);
        chk("t3_full_in_ready", bus.in_ready, 0);
        step();
        bus.in_valid = 1'b0;
        drain("t3_drain");
        for (int k = 0; k < 8; k++) exp_q.push_back({1'b0, addi_inst(k + 1, k)});
        for (int k = 0; k < 8; k++)
            exp_q.push_back({1'b1, addi_inst(k + 1, k) | 32'h00080800});
        compare_mon("t3_seq");
        chk("t3_sync", bus.qed_sync, 1);

        // illegal original add x17,x1,x2
        issue(32'h002088B3);
        @(negedge clk);
        chk("t4_illegal_pulse", bus.illegal_orig, 1);
        chk("t4_nop_issued", bus.out_inst, NOP);
        step();
        @(negedge clk);
        chk("t4_illegal_cleared", bus.illegal_orig, 0);
        step();
        pulse_exec();
        drain("t4_drain");
        exp_q.push_back({1'b0, NOP});
        exp_q.push_back({1'b1, NOP});
        compare_mon("t4_seq");

        // decoder stall of 5 cycles in DUP mode
        for (int k = 10; k < 13; k++) issue(addi_inst(k + 1, k));
        pulse_exec();
        step();
        bus.out_ready = 1'b0;
        a = addi_inst(11, 10) | 32'h00080800;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk($sformatf("t5_hold_%0d", i), {bus.out_valid, bus.out_is_dup, bus.out_inst},
                {2'b11, a});
            chk($sformatf("t5_sync_%0d", i), bus.qed_sync, 0);
        end
        step();
        bus.out_ready = 1'b1;
        drain("t5_drain");
        for (int k = 10; k < 13; k++) exp_q.push_back({1'b0, addi_inst(k + 1, k)});
        for (int k = 10; k < 13; k++)
            exp_q.push_back({1'b1, addi_inst(k + 1, k) | 32'h00080800});
        compare_mon("t5_seq");

        // async reset with three duplicates queued and an original in flight
        for (int k = 1; k < 4; k++) issue(addi_inst(k, 100 + k));
        bus.out_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("t6_rst_out_valid", bus.out_valid, 0);
        chk("t6_rst_sync", bus.qed_sync, 1);
        chk("t6_rst_in_ready", bus.in_ready, 0);
        @(negedge clk);
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        step();
        mon_q.delete();
        @(negedge clk);
        chk("t6_post_in_ready", bus.in_ready, 1);
        chk("t6_post_sync", bus.qed_sync, 1);
        step();
        // empty queue: DUP entered and left with nothing issued
        pulse_exec();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("t6_no_issue_%0d", i), bus.out_valid, 0);
        end
        chk("t6_back_orig", bus.in_ready, 1);
        step();
        compare_mon("t6_seq");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
